regfile_wb_sched: RTL

- Write-back scheduler and scoreboard for the 32x32 register file.
- Shares the file's single write port (regWr/addrWr/data) between N result producers (ALU, load, mul/div) using round-robin arbitration.
- Tracks which registers have an in-flight write, so issue logic can stall on RAW and WAW hazards.
- Sits between the execute units and the register file write port; the issue stage queries its busy outputs.

---
 rtl/regfile_wb_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Brief    : Round-robin write-back arbiter for the register file write port,
//            plus a pending-write scoreboard that flags RAW/WAW hazards to issue.
// Options  : WB_BYPASS_EN - forward the accepted result to the issue operands
//            in the accept cycle and mask busy with it.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic                 regWr,
    output logic [4:0]           addrWr,
    output logic [31:0]          wb_data,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_addr,
    output logic                 iss_stall,
    input  logic [4:0]           rd_addr0,
    input  logic [4:0]           rd_addr1,
    output logic                 busy0,
    output logic                 busy1,
    output logic                 byp_hit0,
    output logic                 byp_hit1,
    output logic [31:0]          byp_data0,
    output logic [31:0]          byp_data1
);

    logic [PTR_W-1:0]  r_ptr;
    logic [31:0]       r_pending;
    logic              r_regwr;
    logic [4:0]        r_addrwr;
    logic [31:0]       r_wbdata;

    logic [NREQ-1:0]   w_hi_mask;
    logic [NREQ-1:0]   w_hi_req;
    logic [NREQ-1:0]   w_cand;
    logic              w_found;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_accept;
    logic [NREQ-1:0]   w_grant;
    logic [4:0]        w_acc_addr;
    logic [31:0]       w_acc_data;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              w_iss_set;
    logic [31:0]       w_pending_nxt;

    // Requesters at or above the pointer take priority; otherwise wrap to the lowest.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_hi_mask[i] = (PTR_W'(i) >= r_ptr);
        end
    end

    assign w_hi_req = req_valid & w_hi_mask;
    assign w_cand   = (|w_hi_req) ? w_hi_req : req_valid;

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_cand[i]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    assign w_accept  = w_found & ~rst;
    assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_grant    = '0;
        w_acc_addr = '0;
        w_acc_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_accept && (w_gnt_idx == PTR_W'(i))) begin
                w_grant[i] = 1'b1;
                w_acc_addr = req_addr[5*i +: 5];
                w_acc_data = req_data[32*i +: 32];
            end
        end
    end

    assign req_ready = w_grant;

    assign iss_stall = iss_valid & (iss_addr != 5'd0) & r_pending[iss_addr];
    assign w_iss_set = iss_valid & ~iss_stall & (iss_addr != 5'd0);

    // Set is applied after clear so a newly issued producer wins over a retiring one.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_accept) begin
            w_pending_nxt[w_acc_addr] = 1'b0;
        end
        if (w_iss_set) begin
            w_pending_nxt[iss_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_pending <= '0;
            r_regwr   <= 1'b0;
            r_addrwr  <= '0;
            r_wbdata  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_regwr   <= w_accept & (w_acc_addr != 5'd0);
            if (w_accept) begin
                r_ptr    <= w_ptr_nxt;
                r_addrwr <= w_acc_addr;
                r_wbdata <= w_acc_data;
            end
        end
    end

    assign regWr   = r_regwr;
    assign addrWr  = r_addrwr;
    assign wb_data = r_wbdata;

`ifdef WB_BYPASS_EN
    assign byp_hit0  = w_accept & (w_acc_addr == rd_addr0) & (rd_addr0 != 5'd0);
    assign byp_hit1  = w_accept & (w_acc_addr == rd_addr1) & (rd_addr1 != 5'd0);
    assign byp_data0 = byp_hit0 ? w_acc_data : 32'd0;
    assign byp_data1 = byp_hit1 ? w_acc_data : 32'd0;
`else
    assign byp_hit0  = 1'b0;
    assign byp_hit1  = 1'b0;
    assign byp_data0 = 32'd0;
    assign byp_data1 = 32'd0;
`endif

    assign busy0 = r_pending[rd_addr0] & (rd_addr0 != 5'd0) & ~byp_hit0;
    assign busy1 = r_pending[rd_addr1] & (rd_addr1 != 5'd0) & ~byp_hit1;

endmodule
`default_nettype wire
